titan_timer_unit: RTL and testbench



---
 rtl/titan_timer_unit.sv | 115 +++++++++++
 tb/tb_titan_timer_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/titan_timer_unit.sv
// Machine-mode timer and software-interrupt block: 64-bit mtime, mtimecmp and msip
// behind a single-cycle Wishbone slave, driving the timer and software interrupt lines.
module titan_timer_unit #(
    parameter int unsigned PRESCALE    = 1,
    parameter logic [63:0] MTIME_RESET = 64'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        xint_mtip_o,
    output logic        xint_msip_o
);

    localparam logic [15:0] PreMax = 16'(PRESCALE - 1);

    logic [15:0] cnt_q, cnt_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] dat_q, dat_d;
    logic        mtip_q, mtip_d;
    logic        msip_o_q;

    logic        req;
    logic        tick;
    logic        mapped;
    logic        wr;
    logic [2:0]  idx;
    logic [31:0] wmask;
    logic [31:0] rdata;
    logic        unused_addr;

    assign idx         = wb_addr_i[4:2];
    assign unused_addr = ^wb_addr_i[1:0];
    assign req         = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    assign tick        = (cnt_q == PreMax);
    assign wmask       = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign wr          = req & wb_we_i & mapped;

    always_comb begin
        mapped = 1'b0;
        rdata  = '0;
        case (idx)
            3'd0: begin mapped = 1'b1; rdata = {31'b0, msip_q}; end
            3'd2: begin mapped = 1'b1; rdata = mtimecmp_q[31:0]; end
            3'd3: begin mapped = 1'b1; rdata = mtimecmp_q[63:32]; end
            3'd4: begin mapped = 1'b1; rdata = mtime_q[31:0]; end
            3'd5: begin mapped = 1'b1; rdata = mtime_q[63:32]; end
            default: begin mapped = 1'b0; rdata = '0; end
        endcase
    end

    always_comb begin
        cnt_d      = tick ? 16'd0 : cnt_q + 16'd1;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        // A bus write to one mtime word freezes the other word, suppressing the tick's carry.
        if (wr) begin
            case (idx)
                3'd0: if (wb_sel_i[0]) msip_d = wb_dat_i[0];
                3'd2: mtimecmp_d[31:0]  = (mtimecmp_q[31:0] & ~wmask) | (wb_dat_i & wmask);
                3'd3: mtimecmp_d[63:32] = (mtimecmp_q[63:32] & ~wmask) | (wb_dat_i & wmask);
                3'd4: mtime_d = {mtime_q[63:32], (mtime_q[31:0] & ~wmask) | (wb_dat_i & wmask)};
                3'd5: mtime_d = {(mtime_q[63:32] & ~wmask) | (wb_dat_i & wmask), mtime_q[31:0]};
                default: ;
            endcase
        end
        ack_d  = req & mapped;
        err_d  = req & ~mapped;
        dat_d  = (req & mapped & ~wb_we_i) ? rdata : 32'd0;
        mtip_d = (mtime_q >= mtimecmp_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            mtime_q    <= MTIME_RESET;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= '0;
            mtip_q     <= 1'b0;
            msip_o_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            dat_q      <= dat_d;
            mtip_q     <= mtip_d;
            msip_o_q   <= msip_q;
        end
    end

    assign wb_dat_o    = dat_q;
    assign wb_ack_o    = ack_q;
    assign wb_err_o    = err_q;
    assign xint_mtip_o = mtip_q;
    assign xint_msip_o = msip_o_q;

endmodule

// File: tb/tb_titan_timer_unit.sv
// Directed bench for titan_timer_unit: instance A runs PRESCALE=4, instance B PRESCALE=1,
// sharing clock, reset and bus payload; each access strobes only one of them.
module tb_titan_timer_unit;

    logic        clk;
    logic        rst;
    logic [4:0]  addr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        we;
    logic        stb_a, stb_b;
    logic [31:0] dat_a, dat_b;
    logic        ack_a, ack_b, err_a, err_b;
    logic        mtip_a, mtip_b, msip_a, msip_b;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] rd;
    logic        ack, err;
    int          acks;

    titan_timer_unit #(.PRESCALE(4), .MTIME_RESET(64'h0)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .wb_addr_i(addr), .wb_dat_i(wdat), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(stb_a), .wb_stb_i(stb_a), .wb_dat_o(dat_a),
        .wb_ack_o(ack_a), .wb_err_o(err_a), .xint_mtip_o(mtip_a), .xint_msip_o(msip_a)
    );

    titan_timer_unit #(.PRESCALE(1), .MTIME_RESET(64'h0)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .wb_addr_i(addr), .wb_dat_i(wdat), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(stb_b), .wb_stb_i(stb_b), .wb_dat_o(dat_b),
        .wb_ack_o(ack_b), .wb_err_o(err_b), .xint_mtip_o(mtip_b), .xint_msip_o(msip_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge; request edge is the next posedge; returns two cycles later.
    task automatic access(input bit inst_b, input logic w, input logic [2:0] idx,
                          input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rdat, output logic ak, output logic er);
        addr = {idx, 2'b00};
        wdat = d;
        sel  = s;
        we   = w;
        if (inst_b) stb_b = 1'b1;
        else        stb_a = 1'b1;
        @(negedge clk);
        rdat = inst_b ? dat_b : dat_a;
        ak   = inst_b ? ack_b : ack_a;
        er   = inst_b ? err_b : err_a;
        stb_a = 1'b0;
        stb_b = 1'b0;
        we    = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; addr = '0; wdat = '0; sel = '0; we = 1'b0; stb_a = 1'b0; stb_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_outs_a", {ack_a, err_a, dat_a, mtip_a, msip_a}, '0);
        chk("rst_outs_b", {ack_b, err_b, dat_b, mtip_b, msip_b}, '0);
        rst = 1'b0;

        // Reset contents via B; A counts undisturbed (tick every 4th edge).
        access(1'b1, 1'b0, 3'd4, '0, 4'hF, rd, ack, err);
        chk("rst_mtime_lo", rd, 32'h0);
        chk("rd_ack", {ack, err}, 2'b10);
        chk("ack_one_cycle", ack_b, 1'b0);
        access(1'b1, 1'b0, 3'd3, '0, 4'hF, rd, ack, err);
        chk("rst_cmp_hi", rd, 32'hFFFF_FFFF);
        chk("rst_mtip", mtip_b, 1'b0);

        access(1'b0, 1'b0, 3'd4, '0, 4'hF, rd, ack, err);
        chk("cnt_presc4_1", rd, 32'd1);
        repeat (14) @(negedge clk);
        access(1'b0, 1'b0, 3'd4, '0, 4'hF, rd, ack, err);
        chk("cnt_presc4_5", rd, 32'd5);

        // Carry 0000_0000_FFFF_FFFF -> 0000_0001_0000_0000.
        access(1'b1, 1'b1, 3'd5, 32'h0, 4'hF, rd, ack, err);
        chk("wr_dat_zero", {rd, ack}, {32'h0, 1'b1});
        access(1'b1, 1'b1, 3'd4, 32'hFFFF_FFFF, 4'hF, rd, ack, err);
        access(1'b1, 1'b0, 3'd5, '0, 4'hF, rd, ack, err);
        chk("carry_hi", rd, 32'd1);
        access(1'b1, 1'b0, 3'd4, '0, 4'hF, rd, ack, err);
        chk("carry_lo", rd, 32'd2);

        // Full wrap to 0.
        access(1'b1, 1'b1, 3'd5, 32'hFFFF_FFFF, 4'hF, rd, ack, err);
        access(1'b1, 1'b1, 3'd4, 32'hFFFF_FFFF, 4'hF, rd, ack, err);
        access(1'b1, 1'b0, 3'd5, '0, 4'hF, rd, ack, err);
        chk("wrap_hi", rd, 32'd0);
        access(1'b1, 1'b0, 3'd4, '0, 4'hF, rd, ack, err);
        chk("wrap_lo", rd, 32'd2);

        // High-word write in the cycle low is FFFF_FFFF: low holds, no carry into high.
        access(1'b1, 1'b1, 3'd4, 32'hFFFF_FFFE, 4'hF, rd, ack, err);
        access(1'b1, 1'b1, 3'd5, 32'h7, 4'hF, rd, ack, err);
        access(1'b1, 1'b0, 3'd5, '0, 4'hF, rd, ack, err);
        chk("hold_lo_hi", rd, 32'd8);
        access(1'b1, 1'b0, 3'd4, '0, 4'hF, rd, ack, err);
        chk("hold_lo_lo", rd, 32'd2);

        // Timer interrupt: mtime = 0 at edge Ed, mtimecmp = 0x10.
        access(1'b1, 1'b1, 3'd5, 32'h0, 4'hF, rd, ack, err);
        access(1'b1, 1'b1, 3'd4, 32'h0, 4'hF, rd, ack, err);
        access(1'b1, 1'b1, 3'd3, 32'h0, 4'hF, rd, ack, err);
        access(1'b1, 1'b1, 3'd2, 32'h10, 4'hF, rd, ack, err);
        repeat (11) @(negedge clk);
        chk("mtip_before", mtip_b, 1'b0);
        @(negedge clk);
        chk("mtip_rise", mtip_b, 1'b1);
        access(1'b1, 1'b1, 3'd2, 32'h100, 4'hF, rd, ack, err);
        chk("mtip_clear", mtip_b, 1'b0);

        // Byte lanes on mtimecmp[31:0]: only lane 2 updates.
        access(1'b1, 1'b1, 3'd2, 32'hAABB_CCDD, 4'b0100, rd, ack, err);
        access(1'b1, 1'b0, 3'd2, '0, 4'hF, rd, ack, err);
        chk("cmp_bytelane", rd, 32'h00BB_0100);

        // Software interrupt.
        chk("msip_idle", msip_b, 1'b0);
        access(1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF, 4'b0001, rd, ack, err);
        chk("msip_set", msip_b, 1'b1);
        access(1'b1, 1'b0, 3'd0, '0, 4'hF, rd, ack, err);
        chk("msip_read", rd, 32'h0000_0001);
        access(1'b1, 1'b1, 3'd0, 32'h0, 4'b1110, rd, ack, err);
        chk("msip_sel_ignored", msip_b, 1'b1);
        access(1'b1, 1'b1, 3'd0, 32'h0, 4'b0001, rd, ack, err);
        chk("msip_clr", msip_b, 1'b0);
        access(1'b1, 1'b1, 3'd0, 32'h1, 4'b0000, rd, ack, err);
        chk("sel0_ack", ack, 1'b1);
        chk("sel0_noeffect", msip_b, 1'b0);

        // Unmapped words.
        access(1'b1, 1'b1, 3'd1, 32'hFFFF_FFFF, 4'hF, rd, ack, err);
        chk("err_idx1", {ack, err, rd}, {2'b01, 32'h0});
        chk("err_one_cycle", err_b, 1'b0);
        access(1'b1, 1'b0, 3'd6, '0, 4'hF, rd, ack, err);
        chk("err_idx6", {ack, err, rd}, {2'b01, 32'h0});
        access(1'b1, 1'b1, 3'd7, 32'hFFFF_FFFF, 4'hF, rd, ack, err);
        chk("err_idx7", {ack, err}, 2'b01);
        access(1'b1, 1'b0, 3'd0, '0, 4'hF, rd, ack, err);
        chk("err_nostate", rd, 32'h0);

        // Write beats the tick on mtime low.
        access(1'b1, 1'b1, 3'd4, 32'h55, 4'hF, rd, ack, err);
        access(1'b1, 1'b0, 3'd4, '0, 4'hF, rd, ack, err);
        chk("wr_vs_tick", rd, 32'h56);

        // Held strobe: response every other cycle.
        addr = {3'd0, 2'b00}; we = 1'b0; sel = 4'hF; stb_b = 1'b1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack_b) acks++;
        end
        stb_b = 1'b0;
        chk("held_stb_acks", 64'(acks), 64'd2);
        @(negedge clk);

        // Reset asserted with a request pending: no response.
        addr = {3'd4, 2'b00}; stb_a = 1'b1; rst = 1'b1;
        @(negedge clk);
        chk("rst_drop", {ack_a, err_a}, 2'b00);
        stb_a = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("rst_drop_after", {ack_a, err_a}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
